// File: rtl/vjtag_pkg.sv
// ============================================================================
// vjtag_pkg : shared IR opcodes, FSM encodings and ir_out bit positions
// Rev 1.0   : initial release
// ============================================================================
`default_nettype none

package vjtag_pkg;

  localparam int IR_W = 4;

  localparam logic [IR_W-1:0] IR_BYPASS = 4'h0;
  localparam logic [IR_W-1:0] IR_ID     = 4'h1;
  localparam logic [IR_W-1:0] IR_ADDR   = 4'h2;
  localparam logic [IR_W-1:0] IR_WRITE  = 4'h3;
  localparam logic [IR_W-1:0] IR_READ   = 4'h4;
  localparam logic [IR_W-1:0] IR_STATUS = 4'h5;

  typedef enum logic [2:0] {
    OP_BYPASS = 3'd0,
    OP_ID     = 3'd1,
    OP_ADDR   = 3'd2,
    OP_WRITE  = 3'd3,
    OP_READ   = 3'd4,
    OP_STATUS = 3'd5
  } op_e;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_REQ  = 2'd1;
  localparam state_t ST_DONE = 2'd2;

  localparam int IRO_BUSY     = 3;
  localparam int IRO_OVERRUN  = 2;
  localparam int IRO_RD_VALID = 1;

  // Unused opcodes fall back to BYPASS so the chain length stays at one bit.
  function automatic op_e decode_ir(input logic [IR_W-1:0] ir);
    case (ir)
      IR_ID:     return OP_ID;
      IR_ADDR:   return OP_ADDR;
      IR_WRITE:  return OP_WRITE;
      IR_READ:   return OP_READ;
      IR_STATUS: return OP_STATUS;
      default:   return OP_BYPASS;
    endcase
  endfunction

  function automatic int dr_width(input int addr_w, input int data_w);
    int w;
    w = 32;
    if (addr_w > w) w = addr_w;
    if (data_w > w) w = data_w;
    return w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/vjtag_dr_shift.sv
// ============================================================================
// vjtag_dr_shift : LSB-first DR shift register with capture load, bypass bit
//                  and tdo select (tdo comes straight from flops)
// Rev 1.0        : initial release
// ============================================================================
`default_nettype none

module vjtag_dr_shift #(
  parameter int W = 32
) (
  input  logic         tck,
  input  logic         rst,
  input  logic         tdi,
  input  logic         cdr,
  input  logic         sdr,
  input  logic         load_en,
  input  logic [W-1:0] load_val,
  input  logic         bypass_sel,
  output logic         tdo,
  output logic [W-1:0] sr
);

  logic [W-1:0] sr_q, sr_d;
  logic         bypass_q, bypass_d;

  always_comb begin
    sr_d     = sr_q;
    bypass_d = bypass_q;
    if (cdr) begin
      if (load_en)    sr_d     = load_val;
      if (bypass_sel) bypass_d = 1'b0;
    end else if (sdr) begin
      sr_d = {tdi, sr_q[W-1:1]};
      if (bypass_sel) bypass_d = tdi;
    end
  end

  always_ff @(posedge tck or posedge rst) begin
    if (rst) begin
      sr_q     <= '0;
      bypass_q <= 1'b0;
    end else begin
      sr_q     <= sr_d;
      bypass_q <= bypass_d;
    end
  end

  assign tdo = bypass_sel ? bypass_q : sr_q[0];
  assign sr  = sr_q;

endmodule

`default_nettype wire

// File: rtl/vjtag_bus_ctrl.sv
// ============================================================================
// vjtag_bus_ctrl : Virtual JTAG endpoint to req/ack register-bus master.
//                  Define VJTAG_AUTOINC_EN for post-transaction address increment.
// Rev 1.0        : initial release
// ============================================================================
`default_nettype none

module vjtag_bus_ctrl
  import vjtag_pkg::*;
#(
  parameter int          ADDR_W  = 16,
  parameter int          DATA_W  = 32,
  parameter logic [31:0] USER_ID = 32'h5654_4A31
) (
  input  logic              tck,
  input  logic              rst,
  input  logic              tdi,
  output logic              tdo,
  input  logic [IR_W-1:0]   ir_in,
  output logic [IR_W-1:0]   ir_out,
  input  logic              virtual_state_cdr,
  input  logic              virtual_state_sdr,
  input  logic              virtual_state_e1dr,
  input  logic              virtual_state_pdr,
  input  logic              virtual_state_e2dr,
  input  logic              virtual_state_udr,
  input  logic              virtual_state_cir,
  input  logic              virtual_state_uir,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_ack,
  input  logic [DATA_W-1:0] bus_rdata
);

  localparam int W = dr_width(ADDR_W, DATA_W);

  op_e               op;
  logic              busy;
  logic              launch;
  logic              cap_en;
  logic [W-1:0]      cap_val;
  logic [W-1:0]      sr;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] rd_hold_q, rd_hold_d;
  logic              rd_valid_q, rd_valid_d;
  logic              overrun_q, overrun_d;

  assign op   = decode_ir(ir_in);
  assign busy = (state_q != ST_IDLE);

  always_comb begin
    cap_en  = 1'b1;
    cap_val = '0;
    case (op)
      OP_ID:     cap_val = W'(USER_ID);
      OP_ADDR:   cap_val = W'(addr_q);
      OP_WRITE:  cap_val = '0;
      OP_READ:   cap_val = W'(rd_hold_q);
      OP_STATUS: cap_val = W'({busy, overrun_q, rd_valid_q, busy});
      default:   cap_en  = 1'b0;
    endcase
  end

  vjtag_dr_shift #(
    .W (W)
  ) u_dr_shift (
    .tck        (tck),
    .rst        (rst),
    .tdi        (tdi),
    .cdr        (virtual_state_cdr),
    .sdr        (virtual_state_sdr),
    .load_en    (cap_en),
    .load_val   (cap_val),
    .bypass_sel (op == OP_BYPASS),
    .tdo        (tdo),
    .sr         (sr)
  );

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    bus_addr_d = bus_addr_q;
    wdata_d    = wdata_q;
    we_d       = we_q;
    rd_hold_d  = rd_hold_q;
    rd_valid_d = rd_valid_q;
    overrun_d  = overrun_q;
    launch     = 1'b0;

    if (virtual_state_cdr) begin
      if (op == OP_READ)   rd_valid_d = 1'b0;
      if (op == OP_STATUS) overrun_d  = 1'b0;
    end

    // A read completing on the same edge as a READ capture keeps rd_valid set.
    case (state_q)
      ST_REQ: begin
        if (bus_ack) begin
          state_d = ST_DONE;
          if (!we_q) begin
            rd_hold_d  = bus_rdata;
            rd_valid_d = 1'b1;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
`ifdef VJTAG_AUTOINC_EN
        addr_d  = addr_q + ADDR_W'(1);
`endif
      end
      default: ;
    endcase

    // Commits come after the increment so an explicit ADDR update wins.
    if (virtual_state_udr) begin
      case (op)
        OP_ADDR: addr_d = sr[W-1 -: ADDR_W];
        OP_WRITE: begin
          if (busy) begin
            overrun_d = 1'b1;
          end else begin
            wdata_d = sr[W-1 -: DATA_W];
            we_d    = 1'b1;
            launch  = 1'b1;
          end
        end
        OP_READ: begin
          if (busy) begin
            overrun_d = 1'b1;
          end else begin
            we_d   = 1'b0;
            launch = 1'b1;
          end
        end
        default: ;
      endcase
    end

    if (launch) begin
      bus_addr_d = addr_q;
      state_d    = ST_REQ;
    end
  end

  always_ff @(posedge tck or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      bus_addr_q <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      rd_hold_q  <= '0;
      rd_valid_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      bus_addr_q <= bus_addr_d;
      wdata_q    <= wdata_d;
      we_q       <= we_d;
      rd_hold_q  <= rd_hold_d;
      rd_valid_q <= rd_valid_d;
      overrun_q  <= overrun_d;
    end
  end

  assign bus_req   = (state_q == ST_REQ);
  assign bus_we    = we_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wdata = wdata_q;

  always_comb begin
    ir_out               = '0;
    ir_out[IRO_BUSY]     = busy;
    ir_out[IRO_OVERRUN]  = overrun_q;
    ir_out[IRO_RD_VALID] = rd_valid_q;
  end

  // Pause/IR strobes carry no behaviour here; low bits of sr beyond N are don't-care.
  logic unused_ok;
  assign unused_ok = &{1'b0, virtual_state_e1dr, virtual_state_pdr, virtual_state_e2dr,
                       virtual_state_cir, virtual_state_uir, ^sr};

endmodule

`default_nettype wire

// File: tb/tb_vjtag_bus_ctrl.sv
// ============================================================================
// tb_vjtag_bus_ctrl : directed + randomized bench with a queue-based model
// Rev 1.0           : initial release
// ============================================================================
`default_nettype none

module tb_vjtag_bus_ctrl;

  localparam int          W       = 32;
  localparam logic [31:0] USER_ID = 32'h5654_4A31;

  logic        tck = 1'b0, rst = 1'b0, tdi = 1'b0, tdo;
  logic [3:0]  ir_in = 4'h0, ir_out;
  logic        cdr = 1'b0, sdr = 1'b0, e1dr = 1'b0, pdr = 1'b0, e2dr = 1'b0;
  logic        udr = 1'b0, cir = 1'b0, uir = 1'b0;
  logic        bus_req, bus_we, bus_ack = 1'b0;
  logic [15:0] bus_addr;
  logic [31:0] bus_wdata, bus_rdata = 32'h0;

  int n_checks = 0, n_fail = 0;
  bit chk_en = 0;

  always #5 tck = ~tck;

  vjtag_bus_ctrl #(.ADDR_W(16), .DATA_W(32), .USER_ID(USER_ID)) dut (
    .tck(tck), .rst(rst), .tdi(tdi), .tdo(tdo), .ir_in(ir_in), .ir_out(ir_out),
    .virtual_state_cdr(cdr), .virtual_state_sdr(sdr), .virtual_state_e1dr(e1dr),
    .virtual_state_pdr(pdr), .virtual_state_e2dr(e2dr), .virtual_state_udr(udr),
    .virtual_state_cir(cir), .virtual_state_uir(uir),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit          mq[$];         // DR contents, front = bit presented on tdo
  logic        m_byp;
  logic [15:0] m_addr, m_baddr;
  logic [31:0] m_wdata, m_hold;
  logic        m_rv, m_ov, m_we, m_req;
  int          m_cool;        // cycles left in post-ack gap

  function automatic int decode(input logic [3:0] ir);
    return (ir <= 4'h5) ? int'(ir) : 0;
  endfunction

  function automatic logic [31:0] top_bits(input int n);
    logic [31:0] v = 32'h0;
    for (int j = 0; j < n; j++) v[j] = mq[W-n+j];
    return v;
  endfunction

  task automatic model_load(input logic [31:0] v);
    mq.delete();
    for (int i = 0; i < W; i++) mq.push_back(v[i]);
  endtask

  always @(posedge tck or posedge rst) begin
    int          op;
    bit          was_busy;
    logic [31:0] t;
    if (rst) begin
      model_load(32'h0);
      m_byp = 0; m_addr = 0; m_baddr = 0; m_wdata = 0; m_hold = 0;
      m_rv = 0; m_ov = 0; m_we = 0; m_req = 0; m_cool = 0;
    end else begin
      op       = decode(ir_in);
      was_busy = m_req || (m_cool > 0);
      if (cdr) begin
        case (op)
          0: m_byp = 1'b0;
          1: model_load(USER_ID);
          2: model_load({16'h0, m_addr});
          3: model_load(32'h0);
          4: begin model_load(m_hold); m_rv = 1'b0; end
          5: begin model_load({28'h0, was_busy, m_ov, m_rv, was_busy}); m_ov = 1'b0; end
          default: ;
        endcase
      end else if (sdr) begin
        void'(mq.pop_front());
        mq.push_back(tdi);
        if (op == 0) m_byp = tdi;
      end
      if (m_req && bus_ack) begin
        m_req = 0; m_cool = 1;
        if (!m_we) begin m_hold = bus_rdata; m_rv = 1'b1; end
      end else if (m_cool > 0) begin
        m_cool = 0;
`ifdef VJTAG_AUTOINC_EN
        m_addr = m_addr + 16'd1;
`endif
      end
      if (udr) begin
        case (op)
          2: begin t = top_bits(16); m_addr = t[15:0]; end
          3: if (was_busy) m_ov = 1'b1;
             else begin m_wdata = top_bits(32); m_we = 1; m_baddr = m_addr; m_req = 1; end
          4: if (was_busy) m_ov = 1'b1;
             else begin m_we = 0; m_baddr = m_addr; m_req = 1; end
          default: ;
        endcase
      end
    end
  end

  // ---------------- per-cycle comparison ----------------
  always @(negedge tck) begin
    bit mbusy;
    if (!rst && chk_en) begin
      mbusy = m_req || (m_cool > 0);
      check("bus_req", 32'(bus_req), 32'(m_req));
      check("ir_out", 32'(ir_out), {28'h0, mbusy, m_ov, m_rv, 1'b0});
      check("tdo", 32'(tdo), 32'((decode(ir_in) == 0) ? m_byp : logic'(mq[0])));
      if (m_req) begin
        check("bus_we", 32'(bus_we), 32'(m_we));
        check("bus_addr", 32'(bus_addr), 32'(m_baddr));
        if (m_we) check("bus_wdata", bus_wdata, m_wdata);
      end
    end
  end

  // ---------------- bus responder ----------------
  bit          ack_en = 1, spur_en = 0, rd_force = 0;
  logic [31:0] rd_forced = 32'h0;
  int          ack_delay = 0, ack_wait = 0;

  always @(posedge tck) begin
    #2;
    bus_rdata = rd_force ? rd_forced : $urandom();
    if (bus_ack) bus_ack = 1'b0;
    else if (bus_req) begin
      if (ack_en) begin
        if (ack_wait >= ack_delay) begin bus_ack = 1'b1; ack_wait = 0; end
        else ack_wait++;
      end
    end else begin
      ack_wait = 0;
      if (spur_en && $urandom_range(0, 5) == 0) bus_ack = 1'b1;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc(input bit c, input bit s, input bit e1, input bit u, input bit d, output bit tdo_s);
    cdr = c; sdr = s; e1dr = e1; udr = u; tdi = d;
    @(negedge tck);
    tdo_s = tdo;
    @(posedge tck); #2;
    cdr = 0; sdr = 0; e1dr = 0; udr = 0;
  endtask

  task automatic idle(input int n);
    bit b;
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, b);
  endtask

  task automatic scan(input logic [3:0] ir, input int nbits, input logic [31:0] din,
                      input bit pause, output logic [31:0] dout);
    bit b;
    ir_in = ir;
    dout  = 32'h0;
    cyc(1, 0, 0, 0, 0, b);
    for (int i = 0; i < nbits; i++) begin
      cyc(0, 1, 0, 0, din[i], b);
      dout[i] = b;
      if (pause && i == nbits / 2) begin
        pdr = 1; cyc(0, 0, 0, 0, 0, b); pdr = 0;
      end
    end
    cyc(0, 0, 1, 0, 0, b);
    cyc(0, 0, 0, 1, 0, b);
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while (ir_out[3] !== 1'b0 && k < budget) begin idle(1); k++; end
    check("wait_idle_in_budget", 32'(k < budget), 32'd1);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [31:0] d;
    logic [15:0] exp_a2, exp_cap;
    int          k, pick, nb;
    logic [3:0]  irv;

    #1 rst = 1;
    repeat (2) @(negedge tck);
    check("rst_bus_req", 32'(bus_req), 32'd0);
    check("rst_bus_we", 32'(bus_we), 32'd0);
    check("rst_tdo", 32'(tdo), 32'd0);
    check("rst_ir_out", 32'(ir_out), 32'd0);
    @(posedge tck); #2;
    rst = 0; chk_en = 1;
    idle(2);

    // ID capture
    scan(4'h1, 32, $urandom(), 0, d);
    check("id_scan", d, 32'h5654_4A31);
    check("id_ir_out", 32'(ir_out), 32'd0);

    // Write
    ack_delay = 3;
    scan(4'h2, 16, 32'h0000_0040, 0, d);
    scan(4'h3, 32, 32'hDEAD_BEEF, 0, d);
    check("wr_req_after_udr", 32'(bus_req), 32'd1);
    check("wr_we", 32'(bus_we), 32'd1);
    check("wr_addr", 32'(bus_addr), 32'h0040);
    check("wr_wdata", bus_wdata, 32'hDEAD_BEEF);
    k = 0;
    while (bus_req === 1'b1 && k < 20) begin idle(1); k++; end
    check("wr_req_cycles", 32'(k), 32'd4);

    // Prefetching read
    ack_delay = 1; rd_force = 1; rd_forced = 32'hCAFE_F00D;
    wait_idle(20);
    scan(4'h4, 32, $urandom(), 0, d);
    wait_idle(20);
    check("rd_valid_after_ack", 32'(ir_out), 32'h2);
    rd_forced = 32'h1234_5678;
    scan(4'h4, 32, $urandom(), 0, d);
    check("rd_prefetch_data", d, 32'hCAFE_F00D);
    check("rd_valid_cleared", 32'(ir_out), 32'h8);
    wait_idle(20);
    rd_force = 0;

    // Overrun
    ack_en = 0;
    scan(4'h3, 32, 32'h1111_2222, 0, d);
    scan(4'h3, 32, 32'h3333_4444, 0, d);
    check("ovr_wdata_kept", bus_wdata, 32'h1111_2222);
    scan(4'h5, 32, 32'h0, 0, d);
    check("ovr_status_1", d, 32'h0000_000F);
    ack_en = 1;
    wait_idle(20);
    scan(4'h5, 32, 32'h0, 0, d);
    check("ovr_status_2", d, 32'h0000_0002);

    // Address behaviour across back-to-back writes
`ifdef VJTAG_AUTOINC_EN
    exp_a2 = 16'h0000; exp_cap = 16'h0001;
`else
    exp_a2 = 16'hFFFF; exp_cap = 16'hFFFF;
`endif
    scan(4'h2, 16, 32'h0000_FFFF, 0, d);
    scan(4'h3, 32, 32'hA5A5_0001, 0, d);
    check("inc_addr_1", 32'(bus_addr), 32'hFFFF);
    wait_idle(20);
    scan(4'h3, 32, 32'hA5A5_0002, 0, d);
    check("inc_addr_2", 32'(bus_addr), 32'(exp_a2));
    wait_idle(20);
    scan(4'h2, 16, 32'h0000_FFFF, 0, d);
    check("inc_addr_capture", d[15:0], 32'(exp_cap));

    // Unused opcode behaves as BYPASS
    scan(4'hA, 3, 32'h5, 0, d);
    check("byp_echo", {29'h0, d[2:0]}, 32'h2);
    check("byp_last", 32'(tdo), 32'd1);

    // Randomized phase
    spur_en = 1;
    for (int it = 0; it < 80; it++) begin
      pick = $urandom_range(0, 7);
      irv  = (pick < 6) ? 4'(pick) : ((pick == 6) ? 4'hA : 4'hF);
      nb   = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 32) : ((irv == 4'h2) ? 16 : 32);
      ack_delay = $urandom_range(0, 4);
      ack_en    = ($urandom_range(0, 5) != 0);
      scan(irv, nb, $urandom(), ($urandom_range(0, 3) == 0), d);
      idle($urandom_range(0, 3));
    end
    ack_en = 1; spur_en = 0;
    wait_idle(50);

    // Asynchronous reset during a pending request
    ack_en = 0;
    scan(4'h3, 32, 32'h7777_8888, 0, d);
    check("rst_pre_req", 32'(bus_req), 32'd1);
    #1 rst = 1;
    #1;
    check("rst_async_req", 32'(bus_req), 32'd0);
    check("rst_async_ir_out", 32'(ir_out), 32'd0);
    ack_en = 1;
    @(posedge tck); #2;
    rst = 0;
    idle(1);
    scan(4'h5, 32, 32'h0, 0, d);
    check("rst_status_after", d, 32'h0);
    idle(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
